// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared bus constants and DMA state type for the OAM DMA controller
package gb_bus_pkg;

    localparam logic [15:0] ADDR_DMA_REG = 16'hFF46;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam int          OAM_LEN_DEF  = 160;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        XFER,
        DRAIN
    } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// rtl/oam_dma_ctrl_if.sv - CPU-side and external-side bus bundle around the OAM DMA controller
interface oam_dma_ctrl_if;

    logic [15:0] cpu_A;
    logic [7:0]  cpu_Do;
    logic [7:0]  cpu_Di;
    logic        cpu_wr_n;
    logic        cpu_rd_n;
    logic        cpu_cs_n;
    logic [7:0]  hram_Di;
    logic [15:0] A;
    logic [7:0]  Do;
    logic [7:0]  Di;
    logic        wr_n;
    logic        rd_n;
    logic        cs_n;

    modport master (
        output cpu_A, cpu_Do, cpu_wr_n, cpu_rd_n, cpu_cs_n, hram_Di, Di,
        input  cpu_Di, A, Do, wr_n, rd_n, cs_n
    );

    modport slave (
        input  cpu_A, cpu_Do, cpu_wr_n, cpu_rd_n, cpu_cs_n, hram_Di, Di,
        output cpu_Di, A, Do, wr_n, rd_n, cs_n
    );

endinterface

// File: rtl/oam_dma_bus_mux.sv
// rtl/oam_dma_bus_mux.sv - combinational steering of the external bus and CPU read data
module oam_dma_bus_mux
    import gb_bus_pkg::*;
(
    input  logic        i_dma_active,
    input  logic        i_xfer_rd,
    input  logic [7:0]  i_src_page,
    input  logic [7:0]  i_idx,
    input  logic [7:0]  i_page_reg,
    input  logic [15:0] i_cpu_A,
    input  logic [7:0]  i_cpu_Do,
    input  logic        i_cpu_wr_n,
    input  logic        i_cpu_rd_n,
    input  logic        i_cpu_cs_n,
    input  logic [7:0]  i_hram_Di,
    input  logic [7:0]  i_Di,
    output logic [7:0]  o_cpu_Di,
    output logic [15:0] o_A,
    output logic [7:0]  o_Do,
    output logic        o_wr_n,
    output logic        o_rd_n,
    output logic        o_cs_n
);

    logic w_is_hram;
    logic w_is_dma_reg;

    assign w_is_hram    = (i_cpu_A >= HRAM_LO) && (i_cpu_A <= HRAM_HI);
    assign w_is_dma_reg = (i_cpu_A == ADDR_DMA_REG);

    always_comb begin
        o_cpu_Di = i_Di;
        o_A      = i_cpu_A;
        o_Do     = i_cpu_Do;
        o_wr_n   = i_cpu_wr_n;
        o_rd_n   = i_cpu_rd_n;
        o_cs_n   = i_cpu_cs_n;

        if (w_is_dma_reg) begin
            o_cpu_Di = i_page_reg;
        end else if (w_is_hram) begin
            o_cpu_Di = i_hram_Di;
        end else if (i_dma_active) begin
            o_cpu_Di = 8'hFF;
        end

        // The DMA owns the bus for the whole active window; strobes only assert while reading.
        if (i_dma_active) begin
            o_A    = {i_src_page, i_idx};
            o_wr_n = 1'b1;
            o_rd_n = ~i_xfer_rd;
            o_cs_n = ~i_xfer_rd;
        end
    end

endmodule

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - OAM DMA FSM, page register and OAM write port
// Optional OAM_DMA_ECHO_EN folds source pages 0xE0-0xFF down by 0x20 (echo RAM).
module oam_dma_ctrl
    import gb_bus_pkg::*;
#(
    parameter int BYTE_CYCLES = 4,
    parameter int START_DELAY = 4,
    parameter int OAM_LEN     = OAM_LEN_DEF
) (
    input  logic               clock,
    input  logic               reset,
    oam_dma_ctrl_if.slave      bus,
    output logic [7:0]         oam_addr,
    output logic [7:0]         oam_wdata,
    output logic               oam_we,
    output logic               dma_active
);

    localparam int              CYC_W    = $clog2(BYTE_CYCLES);
    localparam int              DLY_W    = $clog2(START_DELAY + 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BYTE_CYCLES - 1);
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(START_DELAY - 1);
    localparam logic [7:0]      IDX_LAST = 8'(OAM_LEN - 1);

    dma_state_t       r_state, w_next_state;
    logic [7:0]       r_page;
    logic             r_wr_n_q;
    logic [7:0]       r_idx, w_next_idx;
    logic [CYC_W-1:0] r_cyc, w_next_cyc;
    logic [DLY_W-1:0] r_dly, w_next_dly;
    logic             r_oam_we;
    logic [7:0]       r_oam_addr;
    logic [7:0]       r_oam_wdata;
    logic             w_wr_event;
    logic             w_capture;
    logic [7:0]       w_src_page;

    // Only the first cycle of a low write strobe counts, so a long strobe cannot retrigger.
    assign w_wr_event = ~bus.cpu_cs_n & ~bus.cpu_wr_n & r_wr_n_q & (bus.cpu_A == ADDR_DMA_REG);

`ifdef OAM_DMA_ECHO_EN
    assign w_src_page = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;
`else
    assign w_src_page = r_page;
`endif

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_cyc   = r_cyc;
        w_next_dly   = r_dly;
        w_capture    = 1'b0;
        if (w_wr_event) begin
            w_next_state = DELAY;
            w_next_dly   = DLY_LOAD;
            w_next_idx   = '0;
            w_next_cyc   = '0;
        end else begin
            case (r_state)
                IDLE: ;
                DELAY: begin
                    if (r_dly == '0) begin
                        w_next_state = XFER;
                        w_next_idx   = '0;
                        w_next_cyc   = '0;
                    end else begin
                        w_next_dly = r_dly - 1'b1;
                    end
                end
                XFER: begin
                    if (r_cyc == CYC_LAST) begin
                        w_capture  = 1'b1;
                        w_next_cyc = '0;
                        w_next_idx = r_idx + 8'd1;
                        if (r_idx == IDX_LAST) begin
                            w_next_state = DRAIN;
                        end
                    end else begin
                        w_next_cyc = r_cyc + 1'b1;
                    end
                end
                DRAIN:   w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_page      <= 8'hFF;
            r_wr_n_q    <= 1'b1;
            r_idx       <= '0;
            r_cyc       <= '0;
            r_dly       <= '0;
            r_oam_we    <= 1'b0;
            r_oam_addr  <= '0;
            r_oam_wdata <= '0;
        end else begin
            r_state  <= w_next_state;
            r_idx    <= w_next_idx;
            r_cyc    <= w_next_cyc;
            r_dly    <= w_next_dly;
            r_wr_n_q <= bus.cpu_wr_n;
            r_oam_we <= w_capture;
            if (w_wr_event) begin
                r_page <= bus.cpu_Do;
            end
            if (w_capture) begin
                r_oam_addr  <= r_idx;
                r_oam_wdata <= bus.Di;
            end
        end
    end

    assign dma_active = (r_state != IDLE);
    assign oam_we     = r_oam_we;
    assign oam_addr   = r_oam_addr;
    assign oam_wdata  = r_oam_wdata;

    oam_dma_bus_mux u_bus_mux (
        .i_dma_active (dma_active),
        .i_xfer_rd    (r_state == XFER),
        .i_src_page   (w_src_page),
        .i_idx        (r_idx),
        .i_page_reg   (r_page),
        .i_cpu_A      (bus.cpu_A),
        .i_cpu_Do     (bus.cpu_Do),
        .i_cpu_wr_n   (bus.cpu_wr_n),
        .i_cpu_rd_n   (bus.cpu_rd_n),
        .i_cpu_cs_n   (bus.cpu_cs_n),
        .i_hram_Di    (bus.hram_Di),
        .i_Di         (bus.Di),
        .o_cpu_Di     (bus.cpu_Di),
        .o_A          (bus.A),
        .o_Do         (bus.Do),
        .o_wr_n       (bus.wr_n),
        .o_rd_n       (bus.rd_n),
        .o_cs_n       (bus.cs_n)
    );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - testbench for oam_dma_ctrl with cart/WRAM memory model and OAM scoreboard
module tb_oam_dma_ctrl;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  hram;
        logic [7:0]  exp_idle;
        logic [7:0]  exp_dma;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } oam_exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] oam_addr;
    logic [7:0] oam_wdata;
    logic       oam_we;
    logic       dma_active;

    logic [7:0] mem [0:65535];
    oam_exp_t   sb[$];
    vec_t       vecs[8];

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int act_cnt = 0;
    int falls = 0;
    logic prev_act = 1'b0;

    oam_dma_ctrl_if bus ();

    oam_dma_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .oam_addr   (oam_addr),
        .oam_wdata  (oam_wdata),
        .oam_we     (oam_we),
        .dma_active (dma_active)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] fill(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'd1);
    endfunction

    assign bus.Di = mem[bus.A];

    always @(posedge clock) begin
        if (!bus.cs_n && !bus.wr_n) mem[bus.A] <= bus.Do;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (dma_active) act_cnt++;
            if (prev_act && !dma_active) falls++;
            if (oam_we) begin
                pulse_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL oam_we_unexpected actual=%0h required=none", oam_addr);
                end else begin
                    oam_exp_t e;
                    e = sb.pop_front();
                    chk("oam_addr", 32'(oam_addr), 32'(e.addr));
                    chk("oam_wdata", 32'(oam_wdata), 32'(e.data));
                end
            end
        end
        prev_act = dma_active;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu_idle();
        bus.cpu_cs_n = 1'b1;
        bus.cpu_rd_n = 1'b1;
        bus.cpu_wr_n = 1'b1;
        bus.cpu_A    = 16'h0000;
    endtask

    task automatic start_dma(input logic [7:0] page, input logic [7:0] src);
        cyc();
        sb.delete();
        for (int i = 0; i < 160; i++) begin
            oam_exp_t e;
            e.addr = 8'(i);
            e.data = fill({src, 8'(i)});
            sb.push_back(e);
        end
        act_cnt      = 0;
        pulse_cnt    = 0;
        bus.cpu_A    = 16'hFF46;
        bus.cpu_Do   = page;
        bus.cpu_rd_n = 1'b1;
        bus.cpu_cs_n = 1'b0;
        bus.cpu_wr_n = 1'b0;
        cyc();
        cpu_idle();
    endtask

    task automatic wait_pulses(input int n);
        for (int k = 0; k < 2000 && pulse_cnt < n; k++) cyc();
        chk("wait_pulses", 32'(pulse_cnt >= n), 32'd1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 2000 && dma_active; k++) cyc();
        chk("dma_done", 32'(dma_active), 32'd0);
    endtask

    task automatic cpu_read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        bus.cpu_A    = a;
        bus.cpu_cs_n = 1'b0;
        bus.cpu_rd_n = 1'b0;
        #1;
        chk(name, 32'(bus.cpu_Di), 32'(exp));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] echo_src;
        for (int i = 0; i < 65536; i++) mem[i] = fill(16'(i));

        vecs[0] = '{16'hC000, 8'h11, fill(16'hC000), 8'hFF};
        vecs[1] = '{16'hFF90, 8'h3C, 8'h3C,          8'h3C};
        vecs[2] = '{16'hFF46, 8'h22, 8'hFF,          8'h01};
        vecs[3] = '{16'hFFFF, 8'h33, fill(16'hFFFF), 8'hFF};
        vecs[4] = '{16'hFF7F, 8'h44, fill(16'hFF7F), 8'hFF};
        vecs[5] = '{16'hFF80, 8'h55, 8'h55,          8'h55};
        vecs[6] = '{16'hFFFE, 8'h66, 8'h66,          8'h66};
        vecs[7] = '{16'h0150, 8'h77, fill(16'h0150), 8'hFF};

        reset       = 1'b1;
        bus.cpu_Do  = 8'h00;
        bus.hram_Di = 8'h00;
        cpu_idle();
        repeat (3) cyc();
        chk("rst_dma_active", 32'(dma_active), 32'd0);
        chk("rst_oam_we", 32'(oam_we), 32'd0);
        chk("rst_oam_addr", 32'(oam_addr), 32'd0);
        chk("rst_oam_wdata", 32'(oam_wdata), 32'd0);
        reset = 1'b0;
        cyc();

        for (int v = 0; v < 8; v++) begin
            bus.hram_Di = vecs[v].hram;
            cpu_read_chk("idle_cpu_Di", vecs[v].a, vecs[v].exp_idle);
            chk("idle_ext_A", 32'(bus.A), 32'(vecs[v].a));
            chk("idle_ext_rd_n", 32'(bus.rd_n), 32'd0);
            cyc();
        end
        cpu_idle();

        start_dma(8'h01, 8'h01);
        wait_pulses(5);
        for (int v = 0; v < 8; v++) begin
            bus.hram_Di = vecs[v].hram;
            cpu_read_chk("dma_cpu_Di", vecs[v].a, vecs[v].exp_dma);
            chk("dma_ext_page", 32'(bus.A[15:8]), 32'h01);
            chk("dma_ext_rd", 32'({bus.cs_n, bus.rd_n}), 32'd0);
            cyc();
        end
        bus.cpu_A    = 16'hC000;
        bus.cpu_Do   = 8'hAA;
        bus.cpu_rd_n = 1'b1;
        bus.cpu_cs_n = 1'b0;
        bus.cpu_wr_n = 1'b0;
        #1;
        chk("dma_ext_wr_n", 32'(bus.wr_n), 32'd1);
        cyc();
        cpu_idle();
        wait_done();
        chk("xfer1_pulses", 32'(pulse_cnt), 32'd160);
        chk("xfer1_active", 32'(act_cnt), 32'd645);
        chk("xfer1_sb_empty", 32'(sb.size()), 32'd0);
        chk("wram_untouched", 32'(mem[16'hC000]), 32'(fill(16'hC000)));

        falls = 0;
        start_dma(8'hC0, 8'hC0);
        wait_pulses(50);
        chk("restart_old_pulses", 32'(pulse_cnt), 32'd50);
        start_dma(8'hC1, 8'hC1);
        wait_done();
        chk("restart_pulses", 32'(pulse_cnt), 32'd160);
        chk("restart_active", 32'(act_cnt), 32'd646);
        chk("restart_no_gap", 32'(falls), 32'd1);
        chk("restart_sb_empty", 32'(sb.size()), 32'd0);

`ifdef OAM_DMA_ECHO_EN
        echo_src = 8'hC0;
`else
        echo_src = 8'hE0;
`endif
        start_dma(8'hE0, echo_src);
        wait_pulses(3);
        chk("echo_src_page", 32'(bus.A[15:8]), 32'(echo_src));
        wait_done();
        chk("echo_pulses", 32'(pulse_cnt), 32'd160);
        cpu_read_chk("echo_page_rb", 16'hFF46, 8'hE0);
        cyc();
        cpu_idle();

        start_dma(8'h01, 8'h01);
        wait_pulses(80);
        reset = 1'b1;
        sb.delete();
        cyc();
        chk("rst_mid_active", 32'(dma_active), 32'd0);
        chk("rst_mid_we", 32'(oam_we), 32'd0);
        reset = 1'b0;
        pulse_cnt = 0;
        repeat (700) cyc();
        chk("rst_no_pulses", 32'(pulse_cnt), 32'd0);
        cpu_read_chk("rst_page_rb", 16'hFF46, 8'hFF);
        cyc();
        cpu_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
